// File: rtl/microstore_sequencer_pkg.sv
// Shared control-unit definitions: next-state encodings, default address
// width and the bit layout of the sequencing fields inside a microword.
package microstore_sequencer_pkg;

    localparam int IDX_W_DEFAULT = 7;

    // Next-state select field encodings.
    typedef enum logic [2:0] {
        NS_ENCODE      = 3'b000,
        NS_FETCH       = 3'b001,
        NS_BRANCH      = 3'b010,
        NS_WAIT_MOC    = 3'b011,
        NS_JUMP        = 3'b100,
        NS_INC         = 3'b101,
        NS_COND_ENCODE = 3'b110,
        NS_HALT        = 3'b111
    } ns_e;

    // Microword sequencing fields, LSB first: cr_addr, inv, ns.
    localparam int MW_CR_ADDR_LSB = 0;
    localparam int MW_CR_ADDR_W   = IDX_W_DEFAULT;
    localparam int MW_INV_BIT     = MW_CR_ADDR_LSB + MW_CR_ADDR_W;
    localparam int MW_NS_LSB      = MW_INV_BIT + 1;
    localparam int MW_NS_W        = 3;
    localparam int MW_SEQ_W       = MW_NS_LSB + MW_NS_W;

endpackage

// File: rtl/microstore_sequencer_next_mux.sv
// Combinational next-microaddress selection for the microstore sequencer.
module microseq_next_mux
    import microstore_sequencer_pkg::*;
#(
    parameter int               IDX_W     = IDX_W_DEFAULT,
    parameter logic [IDX_W-1:0] TRAP_ADDR = '0
) (
    input  ns_e              ns_i,
    input  logic             inv_i,
    input  logic             cond_i,
    input  logic             moc_i,
    input  logic             wait_expired_i,
    input  logic [IDX_W-1:0] index_i,
    input  logic [IDX_W-1:0] cr_addr_i,
    input  logic [IDX_W-1:0] enc_addr_i,
    output logic [IDX_W-1:0] next_index_o
);

    logic             taken;
    logic [IDX_W-1:0] inc_addr;

    assign taken    = cond_i ^ inv_i;
    assign inc_addr = index_i + IDX_W'(1);  // wraps modulo 2^IDX_W

    // Select the next microaddress from the current microword's ns field.
    always_comb begin
        // NOTE: defaulting every always_comb output first means no path can leave it unassigned, so no latch is inferred.
        next_index_o = index_i;
        case (ns_i)
            NS_ENCODE:      next_index_o = enc_addr_i;
            NS_FETCH:       next_index_o = '0;
            NS_BRANCH:      next_index_o = taken ? cr_addr_i : inc_addr;
            NS_WAIT_MOC: begin
                if (moc_i)               next_index_o = inc_addr;
                else if (wait_expired_i) next_index_o = TRAP_ADDR;
                else                     next_index_o = index_i;
            end
            NS_JUMP:        next_index_o = cr_addr_i;
            NS_INC:         next_index_o = inc_addr;
            NS_COND_ENCODE: next_index_o = taken ? enc_addr_i : inc_addr;
            NS_HALT:        next_index_o = index_i;
            default:        next_index_o = index_i;
        endcase
    end

endmodule

// File: rtl/microstore_sequencer.sv
// Microstore sequencer: holds the microstore address register, the MOC wait
// timeout counter and the halt flag; next-address choice lives in the mux.
module microstore_sequencer
    import microstore_sequencer_pkg::*;
#(
    parameter int               IDX_W     = IDX_W_DEFAULT,
    parameter int               TIMEOUT   = 15,
    parameter logic [IDX_W-1:0] TRAP_ADDR = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       ns,
    input  logic             inv,
    input  logic [IDX_W-1:0] cr_addr,
    input  logic             cond,
    input  logic             moc,
    input  logic [IDX_W-1:0] enc_addr,
    input  logic             stall,
    output logic [IDX_W-1:0] index,
    output logic             mem_timeout,
    output logic             halted
);

    // Counter value on the last permitted non-moc wait cycle.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    ns_e              ns_sel;
    logic [IDX_W-1:0] index_q, index_d;
    logic [7:0]       wait_cnt_q, wait_cnt_d;
    logic             mem_timeout_q;
    logic             halted_q;
    logic             waiting;
    logic             wait_expired;

    assign ns_sel       = ns_e'(ns);
    assign waiting      = (ns_sel == NS_WAIT_MOC) && !moc;
    assign wait_expired = waiting && (wait_cnt_q == WAIT_LAST);

    microseq_next_mux #(
        .IDX_W     (IDX_W),
        .TRAP_ADDR (TRAP_ADDR)
    ) u_next_mux (
        .ns_i           (ns_sel),
        .inv_i          (inv),
        .cond_i         (cond),
        .moc_i          (moc),
        .wait_expired_i (wait_expired),
        .index_i        (index_q),
        .cr_addr_i      (cr_addr),
        .enc_addr_i     (enc_addr),
        .next_index_o   (index_d)
    );

    // Count consecutive non-moc wait cycles; clear on moc, on leaving the wait, or on trap.
    always_comb begin
        wait_cnt_d = '0;
        if (waiting && !wait_expired) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
        end
    end

    // Sequencer state: reset beats stall, stall and halt freeze everything.
    always_ff @(posedge clk) begin
        // NOTE: registers take non-blocking assignments so every flop samples pre-edge values, independent of statement order.
        if (!reset_n) begin
            index_q       <= '0;
            wait_cnt_q    <= '0;
            mem_timeout_q <= 1'b0;
            halted_q      <= 1'b0;
        end else if (halted_q || stall) begin
            mem_timeout_q <= 1'b0;
        end else begin
            index_q       <= index_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= wait_expired;
            halted_q      <= (ns_sel == NS_HALT);
        end
    end

    assign index       = index_q;
    assign mem_timeout = mem_timeout_q;
    assign halted      = halted_q;

endmodule

// File: tb/tb_microstore_sequencer.sv
// Self-checking bench for microstore_sequencer: directed vectors followed by
// randomized stimulus, all compared against a behavioural reference model.
module tb_microstore_sequencer;

    localparam int TIMEOUT = 15;
    localparam int TRAP    = 0;
    localparam int SPACE   = 128;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [2:0] ns;
    logic       inv;
    logic [6:0] cr_addr;
    logic       cond;
    logic       moc;
    logic [6:0] enc_addr;
    logic       stall;
    logic [6:0] index;
    logic       mem_timeout;
    logic       halted;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    // Reference model state.
    int m_index  = 0;
    int m_waited = 0;   // consecutive wait cycles with moc low
    bit m_halt   = 1'b0;
    bit m_to     = 1'b0;

    microstore_sequencer dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .ns          (ns),
        .inv         (inv),
        .cr_addr     (cr_addr),
        .cond        (cond),
        .moc         (moc),
        .enc_addr    (enc_addr),
        .stall       (stall),
        .index       (index),
        .mem_timeout (mem_timeout),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance the reference model by one rising edge using the present inputs.
    task automatic model_edge();
        int inc;
        bit t;
        inc = (m_index + 1) % SPACE;
        t   = cond ^ inv;
        m_to = 1'b0;
        if (!reset_n) begin
            m_index = 0; m_waited = 0; m_halt = 1'b0;
        end else if (!m_halt && !stall) begin
            if (ns != 3'd3) m_waited = 0;
            case (ns)
                3'd0: m_index = enc_addr;
                3'd1: m_index = 0;
                3'd2: m_index = t ? int'(cr_addr) : inc;
                3'd3: begin
                    if (moc) begin
                        m_index = inc; m_waited = 0;
                    end else if (m_waited + 1 == TIMEOUT) begin
                        m_index = TRAP; m_waited = 0; m_to = 1'b1;
                    end else begin
                        m_waited++;
                    end
                end
                3'd4: m_index = cr_addr;
                3'd5: m_index = inc;
                3'd6: m_index = t ? int'(enc_addr) : inc;
                default: m_halt = 1'b1;
            endcase
        end
    endtask

    // One clock: predict, clock, then compare all outputs on the falling edge.
    task automatic step(input string tag);
        model_edge();
        @(posedge clk);
        @(negedge clk);
        check({tag, ".index"},       32'(index),       32'(m_index));
        check({tag, ".mem_timeout"}, 32'(mem_timeout), 32'(m_to));
        check({tag, ".halted"},      32'(halted),      32'(m_halt));
    endtask

    task automatic drv(input int n, input int cr, input bit c, input bit iv,
                       input bit mc, input int enc, input bit st);
        reset_n  = 1'b1;
        ns       = 3'(n);
        cr_addr  = 7'(cr);
        cond     = c;
        inv      = iv;
        moc      = mc;
        enc_addr = 7'(enc);
        stall    = st;
    endtask

    initial begin
        drv(5, 0, 0, 0, 0, 0, 0);
        reset_n = 1'b0;
        @(negedge clk);

        // Reset state, then sequential increment.
        step("reset");
        check("reset.index_lit", 32'(index), 32'd0);
        drv(5, 0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 3; i++) begin
            step("inc");
            check("inc.index_lit", 32'(index), 32'(i));
        end

        // Wrap from 7F to 00.
        drv(4, 'h7F, 0, 0, 0, 0, 0); step("jump7f");
        drv(5, 0, 0, 0, 0, 0, 0);    step("wrap");
        check("wrap.index_lit", 32'(index), 32'h00);

        // Branch, inverted branch, conditional encode, encode, fetch.
        drv(4, 'h10, 0, 0, 0, 0, 0); step("jump10");
        drv(2, 'h2A, 1, 0, 0, 0, 0); step("br_taken");
        check("br_taken.lit", 32'(index), 32'h2A);
        drv(2, 'h2A, 1, 1, 0, 0, 0); step("br_inv");
        check("br_inv.lit", 32'(index), 32'h2B);
        drv(6, 0, 1, 0, 0, 'h15, 0); step("cenc");
        check("cenc.lit", 32'(index), 32'h15);
        drv(6, 0, 1, 1, 0, 'h33, 0); step("cenc_not");
        drv(0, 0, 0, 0, 0, 'h5A, 0); step("encode");
        drv(1, 'h11, 1, 0, 1, 'h22, 0); step("fetch");

        // Short MOC wait that completes normally.
        drv(4, 'h05, 0, 0, 0, 0, 0); step("jump05");
        drv(3, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step("wait_hold");
        check("wait_hold.lit", 32'(index), 32'h05);
        moc = 1'b1; step("wait_done");
        check("wait_done.lit", 32'(index), 32'h06);

        // Full timeout traps after TIMEOUT cycles with a single pulse.
        drv(4, 'h40, 0, 0, 0, 0, 0); step("jump40");
        drv(3, 0, 0, 0, 0, 0, 0);
        for (int i = 1; i < TIMEOUT; i++) step("to_wait");
        step("to_trap");
        check("to_trap.index_lit", 32'(index), 32'(TRAP));
        check("to_trap.pulse_lit", 32'(mem_timeout), 32'd1);
        drv(5, 0, 0, 0, 0, 0, 0); step("to_after");
        check("to_after.pulse_lit", 32'(mem_timeout), 32'd0);

        // moc arriving on the last allowed cycle wins over the trap.
        drv(4, 'h40, 0, 0, 0, 0, 0); step("jump40b");
        drv(3, 0, 0, 0, 0, 0, 0);
        for (int i = 1; i < TIMEOUT; i++) step("late_wait");
        moc = 1'b1; step("late_moc");
        check("late_moc.lit", 32'(index), 32'h41);

        // Stall mid-wait holds the counter; reset mid-wait clears it.
        drv(3, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) step("stall_wait");
        stall = 1'b1;
        for (int i = 0; i < 8; i++) step("stalled");
        stall = 1'b0;
        for (int i = 0; i < 6; i++) step("stall_resume");
        reset_n = 1'b0; step("rst_mid_wait");
        drv(3, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) step("post_rst_wait");

        // Stall during a jump holds index.
        drv(4, 'h33, 0, 0, 0, 0, 1); step("stall_jump");
        reset_n = 1'b0; step("rst_stalled");

        // Halt freezes everything until reset.
        drv(4, 'h22, 0, 0, 0, 0, 0); step("jump22");
        drv(7, 0, 0, 0, 0, 0, 0);    step("halt");
        check("halt.lit", 32'(halted), 32'd1);
        for (int i = 0; i < 6; i++) begin
            drv(i % 8, 'h55, 1, 0, 1, 'h66, i[0]);
            step("halted_hold");
        end
        check("halted_hold.lit", 32'(index), 32'h22);
        reset_n = 1'b0; step("rst_halt");
        check("rst_halt.lit", 32'(halted), 32'd0);

        // Randomized phase.
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = int'($urandom_range(0, 15));
            drv(r < 14 ? r % 7 : 7, int'($urandom_range(0, 127)), 1'($urandom),
                1'($urandom), 1'b0, int'($urandom_range(0, 127)), $urandom_range(0, 9) == 0);
            moc = (ns == 3'd3) ? ($urandom_range(0, 23) == 0) : 1'($urandom);
            if (ns == 3'd3 && $urandom_range(0, 3) != 0) ns = 3'd3;
            if ((m_halt && $urandom_range(0, 7) == 0) || $urandom_range(0, 199) == 0)
                reset_n = 1'b0;
            step("rand");
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
